mux_arbiter_4: RTL and testbench
================================

MUX_ARBITER_4 -- requirements
Module: mux_arbiter_4

Parameters
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, which sets the maximum number of consecutive cycles one requester may own the shared 4:1 mux (legal range 1..255).

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: req[i]=1 means requester i wants the mux.
REQ-005 The block SHALL have port grant, output, 4 bits: one-hot or zero, registered; grant[i]=1 means requester i owns the mux.
REQ-006 The block SHALL have port s0, output, 1 bit: registered mux select MSB.
REQ-007 The block SHALL have port s1, output, 1 bit: registered mux select LSB; {s0,s1}=index of the owner (00->i0, 01->i1, 10->i2, 11->i3).
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever grant is non-zero.

Function
REQ-009 The block SHALL implement a two-state FSM: IDLE (no owner) and OWN (one owner).
REQ-010 In IDLE with req==0, all outputs SHALL hold their IDLE values; {s0,s1} SHALL retain the last owner index.
REQ-011 In IDLE with req!=0, the block SHALL select the winner by round-robin, move to OWN at the next edge, and assert grant/s0/s1/busy from that edge (1-cycle latency).
REQ-012 The round-robin search SHALL start at (ptr+1) mod 4, where ptr is the last granted index, and proceed upward with wrap-around; after reset the search SHALL start at index 0.
REQ-013 On entering OWN, hold_cnt SHALL be loaded with 0 and ptr SHALL be updated to the winner index.
REQ-014 In OWN, hold_cnt SHALL increment by 1 each cycle while req[owner]=1 and hold_cnt<MAX_HOLD-1.
REQ-015 Release SHALL occur when req[owner]=0 (voluntary release) or when hold_cnt==MAX_HOLD-1 and req[owner]=1 (expiry).
REQ-016 On release with another req bit set, the block SHALL hand over directly to the round-robin winner among the non-owner requesters at the next edge, with no idle bubble.
REQ-017 On expiry with no other requester, the block SHALL re-grant the same owner and reset hold_cnt to 0; grant SHALL NOT glitch low.
REQ-018 On voluntary release with req==0, the block SHALL go to IDLE at the next edge; grant and busy SHALL go to 0.
REQ-019 grant SHALL never have more than one bit set, and s0/s1 SHALL change only on the same edge as grant.
REQ-020 When simultaneous requests include the current owner, priority SHALL follow REQ-012 using ptr=owner, so the owner is lowest priority at handover.
REQ-021 hold_cnt SHALL be wide enough for MAX_HOLD-1 and SHALL never wrap.

Reset
REQ-022 While rst=1, regardless of clk, the block SHALL force state=IDLE, grant=0000, s0=0, s1=0, busy=0, hold_cnt=0, ptr=3 (so the first search starts at 0).
REQ-023 Reset asserted mid-OWN SHALL drop grant immediately (asynchronously), and the first arbitration after deassertion SHALL behave exactly as after power-up.

Verification
REQ-024 Check single request: req=0100 from IDLE -> next edge grant=0100, {s0,s1}=10, busy=1; then req=0000 -> next edge grant=0000, busy=0, {s0,s1} stays 10.
REQ-025 Check fairness: req=1111 held, MAX_HOLD=4 -> owners 0,1,2,3,0 in turn, each for exactly 4 cycles, with handover edges back-to-back and no zero-grant cycle.
REQ-026 Check solo expiry: req=0001 held 10 cycles, MAX_HOLD=4 -> grant=0001 continuously, hold_cnt sequence 0,1,2,3,0,1,2,3,0,1.
REQ-027 Check voluntary handover: owner 1 drops req while req=1001 -> next edge grant=1000 (search from 2 finds 3 before 0).
REQ-028 Check async reset: assert rst mid-cycle while grant=0010 -> grant=0000, s0=s1=0, busy=0 before the next edge; after release with req=1111 -> first grant=0001.
REQ-029 Run an assertion over all tests: grant one-hot-or-zero, busy==|grant, {s0,s1}==index(grant) whenever busy=1.

Source files
------------

// File: rtl/mux_arbiter_4.sv
// Round-robin arbiter that owns a shared 4:1 mux select, with a per-owner hold limit.
// Outputs are all registered; an expired owner is re-granted when nobody else is waiting.
module mux_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       s0,
  output logic       s1,
  output logic       busy
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

  localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic             r_state;
  logic [3:0]       r_grant;
  logic [1:0]       r_sel;
  logic             r_busy;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;

  logic             w_state_nxt;
  logic [3:0]       w_grant_nxt;
  logic [1:0]       w_sel_nxt;
  logic             w_busy_nxt;
  logic [1:0]       w_ptr_nxt;
  logic [CNT_W-1:0] w_hold_nxt;

  logic [3:0]       w_owner_oh;
  logic [3:0]       w_cand;
  logic [2:0]       w_pick;
  logic             w_owner_req;
  logic             w_expire;

  // Search starts just above 'last' and wraps; 'last' itself is tried last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] cand;
    rr_pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (r[cand]) rr_pick = {1'b1, cand};
    end
  endfunction

  assign w_owner_oh  = 4'b0001 << r_sel;
  assign w_cand      = (r_state == ST_OWN) ? (req & ~w_owner_oh) : req;
  assign w_pick      = rr_pick(w_cand, r_ptr);
  assign w_owner_req = req[r_sel];
  assign w_expire    = w_owner_req && (r_hold_cnt == HOLD_LAST);

  // NOTE: every signal gets a default first so this block can never infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (w_pick[2]) begin
          w_state_nxt = ST_OWN;
          w_grant_nxt = 4'b0001 << w_pick[1:0];
          w_sel_nxt   = w_pick[1:0];
          w_busy_nxt  = 1'b1;
          w_ptr_nxt   = w_pick[1:0];
          w_hold_nxt  = '0;
        end
      end
      ST_OWN: begin
        if (w_owner_req && !w_expire) begin
          w_hold_nxt = r_hold_cnt + CNT_W'(1);
        end else if (w_pick[2]) begin
          w_grant_nxt = 4'b0001 << w_pick[1:0];
          w_sel_nxt   = w_pick[1:0];
          w_ptr_nxt   = w_pick[1:0];
          w_hold_nxt  = '0;
        end else if (w_expire) begin
          // Lone owner at its limit keeps the mux; only the hold window restarts.
          w_hold_nxt = '0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 4'b0000;
          w_busy_nxt  = 1'b0;
          w_hold_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 4'b0000;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= 4'b0000;
      r_sel      <= 2'b00;
      r_busy     <= 1'b0;
      r_ptr      <= 2'd3;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_sel      <= w_sel_nxt;
      r_busy     <= w_busy_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  assign grant = r_grant;
  assign s0    = r_sel[1];
  assign s1    = r_sel[0];
  assign busy  = r_busy;

endmodule

// File: tb/tb_mux_arbiter_4.sv
// Directed bench for mux_arbiter_4 (MAX_HOLD=4): single request, fairness, solo expiry,
// voluntary handover and async reset, plus output invariants checked every cycle.
module tb_mux_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic       s0;
  logic       s1;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  mux_arbiter_4 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant),
    .s0    (s0),
    .s1    (s1),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    case (g)
      4'b0010: idx_of = 2'd1;
      4'b0100: idx_of = 2'd2;
      4'b1000: idx_of = 2'd3;
      default: idx_of = 2'd0;
    endcase
  endfunction

  // Invariants sampled mid-cycle across every test.
  always @(negedge clk) begin
    check("inv_onehot0", 32'($onehot0(grant)), 32'd1);
    check("inv_busy", 32'(busy), 32'(|grant));
    if (busy) check("inv_sel", 32'({s0, s1}), 32'(idx_of(grant)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    req = 4'b0000;
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    tick();
    tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_sel", 32'({s0, s1}), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_hold", 32'(dut.r_hold_cnt), 32'h0);
    rst = 1'b0;

    // Single request, then release to IDLE with select retained.
    req = 4'b0100;
    tick();
    check("single_grant", 32'(grant), 32'h4);
    check("single_sel", 32'({s0, s1}), 32'h2);
    check("single_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    tick();
    check("release_grant", 32'(grant), 32'h0);
    check("release_busy", 32'(busy), 32'h0);
    check("release_sel", 32'({s0, s1}), 32'h2);
    tick();
    check("idle_hold_sel", 32'({s0, s1}), 32'h2);
    check("idle_hold_grant", 32'(grant), 32'h0);

    // Fairness: all requesting, each owner exactly 4 cycles, no gaps.
    reset_dut();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 4; c++) begin
        check("fair_grant", 32'(grant), 32'(4'b0001 << (k % 4)));
        check("fair_hold", 32'(dut.r_hold_cnt), 32'(c));
        tick();
      end
    end

    // Solo expiry: same owner re-granted, hold window restarts.
    reset_dut();
    req = 4'b0001;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("solo_grant", 32'(grant), 32'h1);
      check("solo_hold", 32'(dut.r_hold_cnt), 32'(i % 4));
      tick();
    end

    // Voluntary handover: owner 1 drops, search from 2 finds 3 before 0.
    reset_dut();
    req = 4'b0010;
    tick();
    check("vol_own1", 32'(grant), 32'h2);
    req = 4'b1001;
    tick();
    check("vol_grant", 32'(grant), 32'h8);
    check("vol_sel", 32'({s0, s1}), 32'h3);
    check("vol_busy", 32'(busy), 32'h1);

    // Async reset mid-ownership, then arbitration as after power-up.
    reset_dut();
    req = 4'b0010;
    tick();
    check("ar_pre_grant", 32'(grant), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check("ar_grant", 32'(grant), 32'h0);
    check("ar_sel", 32'({s0, s1}), 32'h0);
    check("ar_busy", 32'(busy), 32'h0);
    #2;
    rst = 1'b0;
    req = 4'b1111;
    tick();
    check("ar_first_grant", 32'(grant), 32'h1);
    check("ar_first_sel", 32'({s0, s1}), 32'h0);
    check("ar_first_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
